// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, op_a, op_b,
    input  busy, done, diff, borrow, overflow
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, diff, borrow, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, one full-adder cell
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, sign_a_q, sign_b_q, borrow_q, overflow_q;

  logic             b_inv, sum_d, carry_d, last_bit, accept;
  logic [WIDTH-1:0] acc_d;

  // Full-adder cell on the current LSBs, subtracting by adding the inverted B bit
  always_comb begin
    b_inv    = ~b_q[0];
    sum_d    = a_q[0] ^ b_inv ^ carry_q;
    carry_d  = (a_q[0] & b_inv) | (a_q[0] & carry_q) | (b_inv & carry_q);
    acc_d    = {sum_d, acc_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
    accept   = (state_q == S_IDLE) && bus.start;
  end

  // Next-state and status outputs; busy covers both SHIFT and DONE
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, bit-serial shifting, and result publication on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.op_a;
      b_q      <= bus.op_b;
      sign_a_q <= bus.op_a[WIDTH-1];
      sign_b_q <= bus.op_b[WIDTH-1];
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
    end else if (state_q == S_SHIFT) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_q + CW'(1);
      // The final sum bit is the result sign, so the outputs land exactly as DONE begins
      if (last_bit) begin
        diff_q     <= acc_d;
        borrow_q   <= ~carry_d;
        overflow_q <= (sign_a_q ^ sign_b_q) & (sum_d ^ sign_a_q);
      end
    end
  end

  // Results are only ever driven from the published registers
  always_comb begin
    bus.diff     = diff_q;
    bus.borrow   = borrow_q;
    bus.overflow = overflow_q;
  end
endmodule
